// File: rtl/prediction_stat_tracker.sv
// Per-predictor accuracy counters and trend FSMs feeding the SP/LHP/GHP arbiter.
// Optional periodic halving of counters: define PREDICTION_STAT_DECAY_EN.
module prediction_stat_tracker #(
   parameter int STAT_COUNTER_WIDTH = 5,
   parameter int WRONG_PENALTY      = 2,
   parameter int DECAY_PERIOD_LOG2  = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stat_clear,
   input  logic                          update_valid,
   input  logic                          actual_taken,
   input  logic                          SP_prediction,
   input  logic                          LHP_prediction,
   input  logic                          GHP_prediction,
   output logic [STAT_COUNTER_WIDTH-1:0] SP_stat_count,
   output logic [STAT_COUNTER_WIDTH-1:0] LHP_stat_count,
   output logic [STAT_COUNTER_WIDTH-1:0] GHP_stat_count,
   output logic [3:0]                    SP_trend_decode,
   output logic [3:0]                    LHP_trend_decode,
   output logic [3:0]                    GHP_trend_decode
);

   localparam int W = STAT_COUNTER_WIDTH;
   localparam logic [W:0] MAXV = {1'b0, {W{1'b1}}};
   localparam logic [W:0] PEN  = (W+1)'(WRONG_PENALTY);

   if (WRONG_PENALTY < 1 || WRONG_PENALTY > 3 || DECAY_PERIOD_LOG2 < 1)
   begin : g_cfg_err
      $error("prediction_stat_tracker: bad parameter");
   end

   typedef enum logic [1:0] {
      COLD    = 2'd0,
      FALLING = 2'd1,
      RISING  = 2'd2,
      STRONG  = 2'd3
   } trend_t;

   logic         w_upd;
   logic         w_decay;
   logic [2:0]   w_pred;
   logic [2:0]   w_correct;
   logic [W:0]   w_ext     [3];
   logic [W-1:0] w_cnt_nxt [3];
   logic [W-1:0] r_cnt     [3];
   trend_t       r_state   [3];
   trend_t       w_state_nxt [3];
   logic [3:0]   w_dec     [3];

   assign w_upd     = update_valid & ~stat_clear;
   assign w_pred    = {GHP_prediction, LHP_prediction, SP_prediction};
   assign w_correct = ~(w_pred ^ {3{actual_taken}});

`ifdef PREDICTION_STAT_DECAY_EN
   logic [DECAY_PERIOD_LOG2-1:0] r_upd_cnt;

   // Halve on the update that wraps the period counter.
   assign w_decay = w_upd & (&r_upd_cnt);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_upd_cnt <= '0;
      else if (stat_clear)
         r_upd_cnt <= '0;
      else if (w_upd)
         r_upd_cnt <= r_upd_cnt + 1'b1;
   end
`else
   assign w_decay = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_ext[i]     = {1'b0, r_cnt[i]};
         w_cnt_nxt[i] = r_cnt[i];
         if (w_upd) begin
            if (w_correct[i]) begin
               w_ext[i] = w_ext[i] + 1'b1;
               if (w_ext[i] > MAXV)
                  w_ext[i] = MAXV;
            end else if (w_ext[i] < PEN) begin
               w_ext[i] = '0;
            end else begin
               w_ext[i] = w_ext[i] - PEN;
            end
            if (w_decay)
               w_ext[i] = w_ext[i] >> 1;
            w_cnt_nxt[i] = w_ext[i][W-1:0];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_state_nxt[i] = r_state[i];
         if (w_upd) begin
            unique case (r_state[i])
               COLD,
               FALLING: w_state_nxt[i] = w_correct[i] ? RISING : COLD;
               RISING,
               STRONG:  w_state_nxt[i] = w_correct[i] ? STRONG : FALLING;
               default: w_state_nxt[i] = COLD;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            r_cnt[i]   <= '0;
            r_state[i] <= COLD;
         end
      end else if (stat_clear) begin
         for (int i = 0; i < 3; i++) begin
            r_cnt[i]   <= '0;
            r_state[i] <= COLD;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            r_cnt[i]   <= w_cnt_nxt[i];
            r_state[i] <= w_state_nxt[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         unique case (r_state[i])
            COLD:    w_dec[i] = 4'b0001;
            FALLING: w_dec[i] = 4'b0010;
            RISING:  w_dec[i] = 4'b0100;
            STRONG:  w_dec[i] = 4'b1000;
            default: w_dec[i] = 4'b0001;
         endcase
      end
   end

   assign SP_stat_count    = r_cnt[0];
   assign LHP_stat_count   = r_cnt[1];
   assign GHP_stat_count   = r_cnt[2];
   assign SP_trend_decode  = w_dec[0];
   assign LHP_trend_decode = w_dec[1];
   assign GHP_trend_decode = w_dec[2];

endmodule

// File: tb/tb_prediction_stat_tracker.sv
// Scoreboard bench for prediction_stat_tracker against an arithmetic model.
// Build with PREDICTION_STAT_DECAY_EN to exercise counter halving.
module tb_prediction_stat_tracker;

   localparam int W   = 5;
   localparam int PEN = 2;
   localparam int DP  = 6;
   localparam int MAX = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stat_clear = 1'b0;
   logic update_valid = 1'b0;
   logic actual_taken = 1'b0;
   logic SP_prediction = 1'b0;
   logic LHP_prediction = 1'b0;
   logic GHP_prediction = 1'b0;
   logic [W-1:0] SP_stat_count, LHP_stat_count, GHP_stat_count;
   logic [3:0] SP_trend_decode, LHP_trend_decode, GHP_trend_decode;

   prediction_stat_tracker #(
      .STAT_COUNTER_WIDTH(W),
      .WRONG_PENALTY(PEN),
      .DECAY_PERIOD_LOG2(DP)
   ) dut (
      .clk(clk),
      .rst(rst),
      .stat_clear(stat_clear),
      .update_valid(update_valid),
      .actual_taken(actual_taken),
      .SP_prediction(SP_prediction),
      .LHP_prediction(LHP_prediction),
      .GHP_prediction(GHP_prediction),
      .SP_stat_count(SP_stat_count),
      .LHP_stat_count(LHP_stat_count),
      .GHP_stat_count(GHP_stat_count),
      .SP_trend_decode(SP_trend_decode),
      .LHP_trend_decode(LHP_trend_decode),
      .GHP_trend_decode(GHP_trend_decode)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0][W-1:0] cnt;
      logic [2:0][3:0]   dec;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int errors  = 0;

   // Model: tr 0=COLD 1=FALLING 2=RISING 3=STRONG, decode = 1 << tr
   int m_cnt[3];
   int m_tr[3];
   int m_upd;

   function automatic exp_t snap();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         e.cnt[i] = m_cnt[i][W-1:0];
         e.dec[i] = 4'(1 << m_tr[i]);
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cnt[i] = 0;
         m_tr[i]  = 0;
      end
      m_upd = 0;
   endtask

   task automatic model(input bit clr, input bit v, input bit a,
                        input bit [2:0] p);
      bit dk;
      if (clr) begin
         model_reset();
      end else if (v) begin
         m_upd = (m_upd + 1) % (1 << DP);
`ifdef PREDICTION_STAT_DECAY_EN
         dk = (m_upd == 0);
`else
         dk = 1'b0;
`endif
         for (int i = 0; i < 3; i++) begin
            if (p[i] == a) begin
               m_cnt[i] = (m_cnt[i] + 1 > MAX) ? MAX : m_cnt[i] + 1;
               m_tr[i]  = (m_tr[i] >= 2) ? 3 : 2;
            end else begin
               m_cnt[i] = (m_cnt[i] - PEN < 0) ? 0 : m_cnt[i] - PEN;
               m_tr[i]  = (m_tr[i] >= 2) ? 1 : 0;
            end
            if (dk) m_cnt[i] = m_cnt[i] / 2;
         end
      end
   endtask

   task automatic check(input string nm, input exp_t e);
      exp_t g;
      g.cnt = {GHP_stat_count, LHP_stat_count, SP_stat_count};
      g.dec = {GHP_trend_decode, LHP_trend_decode, SP_trend_decode};
      vectors++;
      if (g !== e) begin
         errors++;
         $display("FAIL %s: got cnt=%0d/%0d/%0d dec=%b/%b/%b want cnt=%0d/%0d/%0d dec=%b/%b/%b",
                  nm, g.cnt[0], g.cnt[1], g.cnt[2], g.dec[0], g.dec[1], g.dec[2],
                  e.cnt[0], e.cnt[1], e.cnt[2], e.dec[0], e.dec[1], e.dec[2]);
      end
   endtask

   task automatic step(input bit clr, input bit v, input bit a,
                       input bit [2:0] p);
      @(negedge clk);
      stat_clear     = clr;
      update_valid   = v;
      actual_taken   = a;
      SP_prediction  = p[0];
      LHP_prediction = p[1];
      GHP_prediction = p[2];
      model(clr, v, a, p);
      q.push_back(snap());
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) check("scoreboard", q.pop_front());
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin : stim
      bit a;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check("reset", snap());
      @(negedge clk);
      rst = 1'b0;

      repeat (10) step(0, 0, 0, 3'b000);
      check("idle", snap());

      for (int i = 0; i < 41; i++) begin
         a = 1'($urandom);
         step(0, 1, a, {3{a}});
      end

      step(1, 0, 0, 3'b000);
      step(0, 1, 1, 3'b111);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 3'b110);
      step(0, 1, 0, 3'b111);

      step(1, 0, 0, 3'b000);
      step(0, 1, 1, 3'b101);
      step(0, 1, 1, 3'b101);

      for (int i = 0; i < 3; i++) step(0, 1, 1, 3'b111);
      step(1, 1, 1, 3'b111);
      step(0, 0, 0, 3'b000);

      for (int i = 0; i < 600; i++) begin
         a = 1'($urandom);
         step(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
              a, 3'($urandom));
      end

      for (int i = 0; i < 5; i++) step(0, 1, 1, 3'b111);
      @(negedge clk);
      update_valid = 1'b0;
      stat_clear   = 1'b0;
      #2 rst = 1'b1;
      #1 model_reset();
      check("async_rst", snap());
      @(negedge clk);
      rst = 1'b0;
      step(0, 1, 1, 3'b011);
      step(0, 1, 0, 3'b011);
      step(0, 0, 0, 3'b000);

      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
